// File: rtl/junction_phase_scheduler_if.sv
// junction_phase_scheduler_if: request/tick inputs and lamp/countdown outputs of the junction scheduler (preempt present under EMERG_PREEMPT_EN)
interface junction_phase_scheduler_if #(parameter int CNT_W = 5);
  logic tick;
  logic [3:0] req;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] phase;
  logic [CNT_W-1:0] countdown;
  logic [3:0] served;
`ifdef EMERG_PREEMPT_EN
  logic [3:0] preempt;
  modport master (output tick, req, preempt, input green, yellow, red, phase, countdown, served);
  modport slave (input tick, req, preempt, output green, yellow, red, phase, countdown, served);
`else
  modport master (output tick, req, input green, yellow, red, phase, countdown, served);
  modport slave (input tick, req, output green, yellow, red, phase, countdown, served);
`endif
endinterface

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: demand-actuated round-robin 4-way phase scheduler, optional EMERG_PREEMPT_EN emergency preemption
module junction_phase_scheduler #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W = 5
) (
  input logic clk1,
  input logic reset,
  junction_phase_scheduler_if.slave bus
);
  localparam logic [1:0] S_GREEN = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;
  logic [1:0] state_q, state_d, phase_q, phase_d, rr_win, tgt, win;
  logic [CNT_W-1:0] cnt_q, cnt_d, el_q, el_d;
  logic [3:0] pend_q, pend_d, green_q, green_d, yellow_q, yellow_d, red_q, red_d, served_q, served_d, own;
  logic rr_found, pre_any, hold, cut, extend;
  assign own = 4'b0001 << phase_q;
`ifdef EMERG_PREEMPT_EN
  always_comb begin
    tgt = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (bus.preempt[i]) tgt = i[1:0];
  end
  assign pre_any = |bus.preempt;
  assign hold = pre_any && tgt == phase_q;
  assign cut = pre_any && tgt != phase_q && el_q >= CNT_W'(GREEN_MIN);
`else
  assign tgt = 2'd0;
  assign pre_any = 1'b0;
  assign hold = 1'b0;
  assign cut = 1'b0;
`endif
  always_comb begin
    rr_found = 1'b0;
    rr_win = phase_q;
    for (int i = 1; i <= 4; i++)
      if (!rr_found && pend_q[phase_q + i[1:0]]) begin
        rr_found = 1'b1;
        rr_win = phase_q + i[1:0];
      end
  end
  assign extend = bus.req[phase_q] && (pend_q & ~own) == 4'd0 && el_q < CNT_W'(GREEN_MAX);
  assign win = pre_any ? tgt : rr_win;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    el_d = el_q;
    served_d = 4'd0;
    if (bus.tick) begin
      if (state_q == S_GREEN) begin
        el_d = &el_q ? el_q : el_q + 1'b1;
        if (cut || (cnt_q == '0 && !hold && !extend)) begin
          state_d = S_YELLOW;
          cnt_d = CNT_W'(YELLOW_TIME - 1);
        end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (state_q == S_YELLOW) begin
        state_d = S_ALLRED;
        cnt_d = CNT_W'(ALLRED_TIME - 1);
      end else if (pre_any || rr_found) begin
        state_d = S_GREEN;
        phase_d = win;
        cnt_d = CNT_W'(GREEN_MIN - 1);
        el_d = CNT_W'(1);
        served_d = 4'b0001 << win;
      end
    end
    pend_d = (pend_q | (bus.req & (state_q == S_GREEN ? ~own : 4'hF))) & ~served_d;
    green_d = state_d == S_GREEN ? 4'b0001 << phase_d : 4'd0;
    yellow_d = state_d == S_YELLOW ? 4'b0001 << phase_d : 4'd0;
    red_d = ~(green_d | yellow_d);
  end
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= S_ALLRED;
      phase_q <= 2'd3;
      cnt_q <= CNT_W'(ALLRED_TIME - 1);
      el_q <= '0;
      pend_q <= '0;
      green_q <= '0;
      yellow_q <= '0;
      red_q <= 4'hF;
      served_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      el_q <= el_d;
      pend_q <= pend_d;
      green_q <= green_d;
      yellow_q <= yellow_d;
      red_q <= red_d;
      served_q <= served_d;
    end
  end
  assign bus.green = green_q;
  assign bus.yellow = yellow_q;
  assign bus.red = red_q;
  assign bus.phase = phase_q;
  assign bus.countdown = cnt_q;
  assign bus.served = served_q;
endmodule

// File: tb/tb_junction_phase_scheduler.sv
// tb_junction_phase_scheduler: directed scenarios plus randomized run against a tick-level behavioural model
module tb_junction_phase_scheduler;
  localparam int GREEN_MIN = 5, GREEN_MAX = 15, YELLOW_TIME = 2, ALLRED_TIME = 1, CNT_W = 5;
  localparam int MG = 0, MY = 1, MR = 2;
  logic clk1 = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0, n_pass = 0;
  int m_mode = MR, m_phase = 3, m_left = ALLRED_TIME, m_el = 0;
  logic [3:0] m_pend = 4'h0, m_served = 4'h0;
  junction_phase_scheduler_if #(.CNT_W(CNT_W)) bus();
  junction_phase_scheduler #(.GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME), .CNT_W(CNT_W)) dut (.clk1(clk1), .reset(reset), .bus(bus));
  always #5 clk1 = ~clk1;

  task automatic model_step();
    logic [3:0] latch, old_pend, own;
    int win;
    own = 4'(1 << m_phase);
    latch = bus.req & ((m_mode == MG) ? ~own : 4'hF);
    old_pend = m_pend;
    m_served = 4'h0;
    win = -1;
    if (reset) begin
      m_mode = MR; m_phase = 3; m_left = ALLRED_TIME; m_el = 0; m_pend = 4'h0;
      return;
    end
    if (bus.tick) begin
      case (m_mode)
        MR: if (m_left > 1) m_left--;
            else begin
              for (int j = 1; j <= 4; j++)
                if (win < 0 && old_pend[(m_phase + j) % 4]) win = (m_phase + j) % 4;
              if (win >= 0) begin
                m_mode = MG; m_phase = win; m_left = GREEN_MIN; m_el = 1; m_served = 4'(1 << win);
              end
            end
        MG: begin
          if (m_left > 1) m_left--;
          else if (!(bus.req[m_phase] && (old_pend & ~own) == 4'h0 && m_el < GREEN_MAX)) begin
            m_mode = MY; m_left = YELLOW_TIME;
          end
          if (m_el < 31) m_el++;
        end
        default: if (m_left > 1) m_left--;
                 else begin m_mode = MR; m_left = ALLRED_TIME; end
      endcase
    end
    m_pend = (old_pend | latch) & ~m_served;
  endtask

  function automatic logic [3:0] m_lamp(input int mode);
    return (m_mode == mode) ? 4'(1 << m_phase) : 4'h0;
  endfunction

  task automatic cycle(input logic t);
    bus.tick = t;
    @(posedge clk1);
    model_step();
    #1;
  endtask

  task automatic one_tick();
    cycle(1'b0); cycle(1'b0); cycle(1'b1);
  endtask

  task automatic do_reset();
    bus.req = 4'h0; reset = 1'b1;
    cycle(1'b0); cycle(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 4'h0; reset = 1'b1;
    cycle(1'b0); cycle(1'b1);
    reset = 1'b0;
    n_checks++; if (bus.red !== 4'hF) $display("FAIL reset_red got=%b exp=1111", bus.red); else n_pass++;
    n_checks++; if ((bus.green | bus.yellow) !== 4'h0) $display("FAIL reset_gy got=%b/%b exp=0", bus.green, bus.yellow); else n_pass++;
    n_checks++; if (bus.countdown !== 5'd0) $display("FAIL reset_countdown got=%0d exp=0", bus.countdown); else n_pass++;
    n_checks++; if (bus.phase !== 2'd3) $display("FAIL reset_phase got=%0d exp=3", bus.phase); else n_pass++;
    n_checks++; if (bus.served !== 4'h0) $display("FAIL reset_served got=%b exp=0", bus.served); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      one_tick();
      n_checks++;
      if ({bus.red, bus.served, bus.countdown} !== {4'hF, 4'h0, 5'd0})
        $display("FAIL idle_tick%0d red/served/cd got=%b/%b/%0d exp=1111/0000/0", k, bus.red, bus.served, bus.countdown);
      else n_pass++;
    end
  endtask

  task automatic test_single_request();
    int ng = 0, ny = 0, ns = 0;
    do_reset();
    cycle(1'b0);
    bus.req = 4'b0100;
    cycle(1'b0);
    bus.req = 4'h0;
    for (int k = 0; k < 12; k++) begin
      one_tick();
      if (k == 0) begin
        n_checks++;
        if (bus.countdown !== 5'(GREEN_MIN - 1)) $display("FAIL grant_countdown got=%0d exp=%0d", bus.countdown, GREEN_MIN - 1); else n_pass++;
      end
      if (bus.green === 4'b0100) ng++;
      if (bus.yellow === 4'b0100) ny++;
      if (bus.served === 4'b0100) ns++; else if (bus.served !== 4'h0) ns += 100;
    end
    n_checks++; if (ng != GREEN_MIN) $display("FAIL single_green_ticks got=%0d exp=%0d", ng, GREEN_MIN); else n_pass++;
    n_checks++; if (ny != YELLOW_TIME) $display("FAIL single_yellow_ticks got=%0d exp=%0d", ny, YELLOW_TIME); else n_pass++;
    n_checks++; if (ns != 1) $display("FAIL single_served got=%0d exp=1", ns); else n_pass++;
    n_checks++; if ({bus.red, bus.phase} !== {4'hF, 2'd2}) $display("FAIL single_idle red/phase got=%b/%0d exp=1111/2", bus.red, bus.phase); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int run = 0;
    do_reset();
    bus.req = 4'hF;
    for (int k = 0; k < 66; k++) begin
      one_tick();
      for (int i = 0; i < 4; i++) if (bus.served[i]) order.push_back(i);
      if (bus.green !== 4'h0) run++;
      else if (run != 0) begin
        n_checks++;
        if (run != GREEN_MIN) $display("FAIL rr_green_len got=%0d exp=%0d", run, GREEN_MIN); else n_pass++;
        run = 0;
      end
    end
    bus.req = 4'h0;
    n_checks++;
    if (order.size() < 8) $display("FAIL rr_grant_count got=%0d exp=>=8", order.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (order[i] != i % 4) $display("FAIL rr_order%0d got=%0d exp=%0d", i, order[i], i % 4); else n_pass++;
      end
    end
  endtask

  task automatic test_extension();
    int grants[$];
    int ng = 0, ny = 0;
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      one_tick();
      if (bus.served[0]) grants.push_back(k);
      if (grants.size() == 1) begin
        if (bus.green[0]) ng++;
        if (bus.yellow[0]) ny++;
      end
      if (k == 17) begin
        n_checks++;
        if (bus.red !== 4'hF) $display("FAIL ext_allred got=%b exp=1111", bus.red); else n_pass++;
      end
    end
    bus.req = 4'h0;
    n_checks++; if (ng != GREEN_MAX) $display("FAIL ext_green_ticks got=%0d exp=%0d", ng, GREEN_MAX); else n_pass++;
    n_checks++; if (ny != YELLOW_TIME) $display("FAIL ext_yellow_ticks got=%0d exp=%0d", ny, YELLOW_TIME); else n_pass++;
    n_checks++;
    if (grants.size() < 2) $display("FAIL ext_regrant got=%0d grants exp=>=2", grants.size());
    else if (grants[1] - grants[0] != GREEN_MAX + YELLOW_TIME + ALLRED_TIME)
      $display("FAIL ext_regrant_gap got=%0d exp=%0d", grants[1] - grants[0], GREEN_MAX + YELLOW_TIME + ALLRED_TIME);
    else n_pass++;
  endtask

  task automatic test_reset_mid_green();
    int ns = 0;
    do_reset();
    bus.req = 4'b0100;
    cycle(1'b0);
    bus.req = 4'h0;
    one_tick(); one_tick();
    n_checks++; if (bus.green !== 4'b0100) $display("FAIL mid_green_setup got=%b exp=0100", bus.green); else n_pass++;
    bus.req = 4'b0001;
    cycle(1'b0);
    bus.req = 4'h0;
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    n_checks++;
    if ({bus.red, bus.green, bus.yellow, bus.countdown, bus.phase, bus.served} !== {4'hF, 4'h0, 4'h0, 5'd0, 2'd3, 4'h0})
      $display("FAIL mid_reset r/g/y/cd/ph/sv got=%b/%b/%b/%0d/%0d/%b exp=1111/0000/0000/0/3/0000",
        bus.red, bus.green, bus.yellow, bus.countdown, bus.phase, bus.served);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      one_tick();
      if (bus.served !== 4'h0) ns++;
    end
    n_checks++; if (ns != 0) $display("FAIL mid_reset_pending served_pulses got=%0d exp=0", ns); else n_pass++;
  endtask

  task automatic test_random();
    logic [22:0] got, exp;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.req = 4'($urandom & $urandom);
      reset = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 2) == 0);
      got = {bus.green, bus.yellow, bus.red, bus.phase, bus.countdown, bus.served};
      exp = {m_lamp(MG), m_lamp(MY), ~(m_lamp(MG) | m_lamp(MY)), 2'(m_phase), 5'(m_left - 1), m_served};
      n_checks++;
      if (got !== exp) $display("FAIL random_cycle%0d g/y/r/ph/cd/sv got=%h exp=%h", k, got, exp); else n_pass++;
    end
    reset = 1'b0;
    bus.req = 4'h0;
  endtask

  initial begin
    bus.req = 4'h0;
    bus.tick = 1'b0;
`ifdef EMERG_PREEMPT_EN
    bus.preempt = 4'h0;
`endif
    test_reset();
    test_single_request();
    test_round_robin();
    test_extension();
    test_reset_mid_green();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
